countdown_timer: RTL and testbench

- Minutes:seconds countdown timer, the down-counting counterpart of the stopwatch.
- Loads a BCD preset (00:00..59:59), counts down once per second under start/pause control, and asserts done at 00:00.
- Drives the same four active-low 8-bit segment displays plus the raw 16-bit BCD value.
- Single clock domain; the one-second tick is a clock-enable, never a derived clock.

---
 rtl/countdown_timer.sv | 164 ++++++++++++++++
 tb/tb_countdown_timer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/countdown_timer.sv
// Minutes:seconds BCD countdown timer with start/pause control and done flag.
// Drives the raw BCD value and four active-low seven-segment digit codes.
module countdown_timer #(
  parameter int TICK_DIV = 50000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] preset,
  input  logic        start,
  input  logic        pause,
  output logic [15:0] num,
  output logic        running,
  output logic        done,
  output logic        load_err,
  output logic [7:0]  min1,
  output logic [7:0]  min0,
  output logic [7:0]  sec1,
  output logic [7:0]  sec0
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t          state_r, state_nxt_s;
  logic [15:0]     num_r, num_nxt_s;
  logic [15:0]     preset_r, preset_nxt_s;
  logic [PW-1:0]   presc_r, presc_nxt_s;
  logic            running_r, done_r, load_err_r, load_err_nxt_s;
  logic [15:0]     dec_s;

  function automatic logic bcd_valid(input logic [15:0] v);
    return (v[15:12] <= 4'd5) && (v[11:8] <= 4'd9) &&
           (v[7:4]   <= 4'd5) && (v[3:0]  <= 4'd9);
  endfunction

  // Borrow chain: seconds roll 0 -> 59, minutes-units roll 0 -> 9.
  function automatic logic [15:0] bcd_dec(input logic [15:0] v);
    logic [3:0] m1, m0, s1, s0;
    {m1, m0, s1, s0} = v;
    if (s0 != 4'd0) begin
      s0 = s0 - 4'd1;
    end else begin
      s0 = 4'd9;
      if (s1 != 4'd0) begin
        s1 = s1 - 4'd1;
      end else begin
        s1 = 4'd5;
        if (m0 != 4'd0) begin
          m0 = m0 - 4'd1;
        end else begin
          m0 = 4'd9;
          m1 = m1 - 4'd1;
        end
      end
    end
    return {m1, m0, s1, s0};
  endfunction

  function automatic logic [7:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    return 8'hC0;
      4'd1:    return 8'hF9;
      4'd2:    return 8'hA4;
      4'd3:    return 8'hB0;
      4'd4:    return 8'h99;
      4'd5:    return 8'h92;
      4'd6:    return 8'h82;
      4'd7:    return 8'hF8;
      4'd8:    return 8'h80;
      4'd9:    return 8'h90;
      default: return 8'hFF;
    endcase
  endfunction

  assign dec_s = bcd_dec(num_r);

  // Next-state logic; priority load > pause > start > counting.
  always_comb begin
    state_nxt_s    = state_r;
    num_nxt_s      = num_r;
    preset_nxt_s   = preset_r;
    presc_nxt_s    = presc_r;
    load_err_nxt_s = 1'b0;
    if (load) begin
      if (bcd_valid(preset)) begin
        num_nxt_s    = preset;
        preset_nxt_s = preset;
        presc_nxt_s  = '0;
        state_nxt_s  = IDLE;
      end else begin
        load_err_nxt_s = 1'b1;
      end
    end else if (pause && (state_r == RUN || state_r == PAUSE)) begin
      state_nxt_s = PAUSE;
    end else if (start && state_r != RUN) begin
      case (state_r)
        IDLE: begin
          if (num_r != 16'h0000) begin
            state_nxt_s = RUN;
            presc_nxt_s = '0;
          end else begin
            state_nxt_s = IDLE;
          end
        end
        PAUSE: state_nxt_s = RUN;
        DONE: begin
          num_nxt_s   = preset_r;
          presc_nxt_s = '0;
          state_nxt_s = (preset_r != 16'h0000) ? RUN : IDLE;
        end
        default: state_nxt_s = IDLE;
      endcase
    end else if (state_r == RUN) begin
      if (presc_r == PRESC_MAX) begin
        presc_nxt_s = '0;
        num_nxt_s   = dec_s;
        state_nxt_s = (dec_s == 16'h0000) ? DONE : RUN;
      end else begin
        presc_nxt_s = presc_r + PW'(1);
      end
    end else begin
      state_nxt_s = state_r;
    end
  end

  // State and registered status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= IDLE;
      num_r      <= 16'h0000;
      preset_r   <= 16'h0000;
      presc_r    <= '0;
      running_r  <= 1'b0;
      done_r     <= 1'b0;
      load_err_r <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      num_r      <= num_nxt_s;
      preset_r   <= preset_nxt_s;
      presc_r    <= presc_nxt_s;
      running_r  <= (state_nxt_s == RUN);
      done_r     <= (state_nxt_s == DONE);
      load_err_r <= load_err_nxt_s;
    end
  end

  assign num      = num_r;
  assign running  = running_r;
  assign done     = done_r;
  assign load_err = load_err_r;
  assign min1     = seg_decode(num_r[15:12]);
  assign min0     = seg_decode(num_r[11:8]);
  assign sec1     = seg_decode(num_r[7:4]);
  assign sec0     = seg_decode(num_r[3:0]);

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: seconds-based reference model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_countdown_timer;

  localparam int TICK = 4;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        load = 1'b0;
  logic [15:0] preset = 16'h0000;
  logic        start = 1'b0;
  logic        pause = 1'b0;
  logic [15:0] num;
  logic        running, done, load_err;
  logic [7:0]  min1, min0, sec1, sec0;

  int checks = 0;
  int errors = 0;

  int m_secs = 0;
  int m_pre = 0;
  int m_ph = 0;
  int m_mode = M_IDLE;
  bit m_lerr = 1'b0;

  logic [7:0] seg_tab [0:9] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  countdown_timer #(.TICK_DIV(TICK)) dut (
    .clk(clk), .reset(reset), .load(load), .preset(preset),
    .start(start), .pause(pause), .num(num), .running(running),
    .done(done), .load_err(load_err), .min1(min1), .min0(min0),
    .sec1(sec1), .sec0(sec0)
  );

  always #5 clk = ~clk;

  function automatic int bcd2secs(input logic [15:0] v);
    return (int'(v[15:12]) * 10 + int'(v[11:8])) * 60 + int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  function automatic logic [15:0] secs2bcd(input int s);
    int m, c;
    m = s / 60;
    c = s % 60;
    return {4'(m / 10), 4'(m % 10), 4'(c / 10), 4'(c % 10)};
  endfunction

  function automatic bit bcd_ok(input logic [15:0] v);
    return (v[15:12] <= 4'd5) && (v[11:8] <= 4'd9) && (v[7:4] <= 4'd5) && (v[3:0] <= 4'd9);
  endfunction

  function automatic logic [7:0] seg_of(input logic [3:0] d);
    if (d <= 4'd9) return seg_tab[d];
    return 8'hFF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: time kept as a plain seconds count.
  always @(posedge clk or negedge reset) begin : model
    int s, p, ph, md;
    bit le;
    if (!reset) begin
      m_secs <= 0; m_pre <= 0; m_ph <= 0; m_mode <= M_IDLE; m_lerr <= 1'b0;
    end else begin
      s = m_secs; p = m_pre; ph = m_ph; md = m_mode; le = 1'b0;
      if (load) begin
        if (bcd_ok(preset)) begin
          s = bcd2secs(preset); p = s; ph = 0; md = M_IDLE;
        end else begin
          le = 1'b1;
        end
      end else if (pause && (md == M_RUN || md == M_PAUSE)) begin
        md = M_PAUSE;
      end else if (start && md != M_RUN) begin
        if (md == M_IDLE) begin
          if (s != 0) begin md = M_RUN; ph = 0; end
        end else if (md == M_PAUSE) begin
          md = M_RUN;
        end else begin
          s = p; ph = 0; md = (p != 0) ? M_RUN : M_IDLE;
        end
      end else if (md == M_RUN) begin
        ph = ph + 1;
        if (ph == TICK) begin
          ph = 0;
          s = s - 1;
          if (s == 0) md = M_DONE;
        end
      end
      m_secs <= s; m_pre <= p; m_ph <= ph; m_mode <= md; m_lerr <= le;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin : compare
    logic [15:0] e;
    e = secs2bcd(m_secs);
    chk("cyc_num", num, e);
    chk("cyc_running", running, m_mode == M_RUN);
    chk("cyc_done", done, m_mode == M_DONE);
    chk("cyc_load_err", load_err, m_lerr);
    chk("cyc_min1", min1, seg_of(e[15:12]));
    chk("cyc_min0", min0, seg_of(e[11:8]));
    chk("cyc_sec1", sec1, seg_of(e[7:4]));
    chk("cyc_sec0", sec0, seg_of(e[3:0]));
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic do_load(input logic [15:0] v);
    preset = v; load = 1'b1;
    cycles(1);
    load = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    cycles(1);
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    cycles(2);
    chk("rst_num", num, 16'h0000);
    chk("rst_running", running, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_load_err", load_err, 1'b0);
    chk("rst_sec0", sec0, 8'hC0);
    chk("rst_min1", min1, 8'hC0);
    reset = 1'b1;
    cycles(1);

    do_load(16'h0100);
    do_start();
    chk("start_running", running, 1'b1);
    cycles(4);
    chk("first_tick_num", num, 16'h0059);
    chk("first_tick_sec1", sec1, 8'h92);
    chk("first_tick_sec0", sec0, 8'h90);
    chk("first_tick_min0", min0, 8'hC0);
    chk("model_0059", secs2bcd(m_secs), 16'h0059);

    cycles(2);
    reset = 1'b0;
    #1;
    chk("midrst_num", num, 16'h0000);
    chk("midrst_running", running, 1'b0);
    chk("midrst_done", done, 1'b0);
    chk("midrst_sec1", sec1, 8'hC0);
    reset = 1'b1;
    cycles(10);
    chk("postrst_num", num, 16'h0000);
    chk("postrst_running", running, 1'b0);

    do_load(16'h0002);
    do_start();
    cycles(4);
    chk("cd_0001", num, 16'h0001);
    cycles(4);
    chk("cd_0000", num, 16'h0000);
    chk("cd_done", done, 1'b1);
    chk("cd_running", running, 1'b0);
    cycles(20);
    chk("hold_num", num, 16'h0000);
    chk("hold_done", done, 1'b1);
    do_start();
    chk("restart_num", num, 16'h0002);
    chk("restart_running", running, 1'b1);
    chk("restart_done", done, 1'b0);

    do_load(16'h0010);
    do_start();
    cycles(6);
    chk("pre_pause_num", num, 16'h0009);
    pause = 1'b1;
    cycles(20);
    chk("paused_num", num, 16'h0009);
    chk("paused_running", running, 1'b0);
    pause = 1'b0;
    do_start();
    chk("resume_running", running, 1'b1);
    cycles(1);
    chk("resume_1clk", num, 16'h0009);
    cycles(1);
    chk("resume_2clk", num, 16'h0008);
    chk("model_0008", secs2bcd(m_secs), 16'h0008);

    pause = 1'b1;
    cycles(1);
    pause = 1'b0;
    do_load(16'h0A00);
    chk("bad_min0_err", load_err, 1'b1);
    chk("bad_min0_num", num, 16'h0008);
    cycles(1);
    chk("err_pulse_end", load_err, 1'b0);
    do_load(16'h0060);
    chk("bad_sec1_err", load_err, 1'b1);
    chk("bad_sec1_num", num, 16'h0008);
    chk("bad_keeps_pause", running, 1'b0);
    start = 1'b1; pause = 1'b1;
    cycles(1);
    start = 1'b0; pause = 1'b0;
    chk("sp_in_pause", running, 1'b0);
    chk("sp_in_pause_num", num, 16'h0008);
    do_load(16'h5959);
    chk("max_num", num, 16'h5959);
    chk("max_err", load_err, 1'b0);
    chk("max_min1", min1, 8'h92);
    chk("max_sec0", sec0, 8'h90);

    do_start();
    cycles(2);
    preset = 16'h1234; load = 1'b1; start = 1'b1;
    cycles(1);
    load = 1'b0; start = 1'b0;
    chk("load_start_num", num, 16'h1234);
    chk("load_start_running", running, 1'b0);

    do_load(16'h1000);
    do_start();
    cycles(4);
    chk("min_borrow_num", num, 16'h0959);
    chk("min_borrow_min1", min1, 8'hC0);
    chk("min_borrow_min0", min0, 8'h90);

    do_load(16'h0001);
    do_start();
    cycles(4);
    chk("one_done", done, 1'b1);
    do_load(16'h0A00);
    chk("done_bad_done", done, 1'b1);
    do_start();
    chk("stored_preset_num", num, 16'h0001);
    chk("stored_preset_run", running, 1'b1);

    do_load(16'h0000);
    do_start();
    chk("zero_start_running", running, 1'b0);
    chk("zero_start_num", num, 16'h0000);
    chk("zero_start_done", done, 1'b0);

    cycles(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
